// File: rtl/usr_pkg.sv
`default_nettype none
// usr_pkg -- shared mode codes and FSM state encoding for usr_frame_ser (rev 1.0)
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_SHR  = 3'd1;
   localparam logic [2:0] MODE_SHL  = 3'd2;
   localparam logic [2:0] MODE_ROTR = 3'd3;
   localparam logic [2:0] MODE_ROTL = 3'd4;
   localparam logic [2:0] MODE_LOAD = 3'd5;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/usr_frame_ser.sv
`default_nettype none
// usr_frame_ser -- universal shift register with an automatic LSB-first frame serialiser (rev 1.0)
module usr_frame_ser
   import usr_pkg::*;
#(
   parameter int WIDTH  = 15,
   parameter bit ROT_EN = 1'b1,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [2:0]       mode,
   input  logic             sr_in,
   input  logic             sl_in,
   input  logic [WIDTH-1:0] par_load,
   input  logic             start,
   output logic [WIDTH-1:0] data_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_cnt
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_data;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_done;
   logic [WIDTH-1:0]   w_manual_next;

   always_comb begin
      w_manual_next = r_data;
      case (mode)
         MODE_SHR:  w_manual_next = {sr_in, r_data[WIDTH-1:1]};
         MODE_SHL:  w_manual_next = {r_data[WIDTH-2:0], sl_in};
         MODE_ROTR: if (ROT_EN) w_manual_next = {r_data[0], r_data[WIDTH-1:1]};
         MODE_ROTL: if (ROT_EN) w_manual_next = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
         MODE_LOAD: w_manual_next = par_load;
         default:   w_manual_next = r_data;
      endcase
   end

   // start outranks mode in IDLE; the done cycle is IDLE, so back-to-back frames need no gap
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (start) begin
               r_data  <= par_load;
               r_cnt   <= CNT_W'(WIDTH);
               r_state <= ST_SHIFT;
            end else begin
               r_data <= w_manual_next;
            end
         end else begin
            r_data <= {sr_in, r_data[WIDTH-1:1]};
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
            end
         end
      end
   end

   assign data_out = r_data;
   assign ser_out  = r_data[0];
   assign busy     = (r_state == ST_SHIFT);
   assign done     = r_done;
   assign bit_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_usr_frame_ser.sv
`default_nettype none
// tb_usr_frame_ser -- randomized scoreboard bench for usr_frame_ser against a behavioural model
module tb_usr_frame_ser;

   localparam int W = 15;

   logic          clk = 1'b0;
   logic          RST = 1'b0;
   logic [2:0]    mode = 3'd0;
   logic          sr_in = 1'b0;
   logic          sl_in = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  par_load = '0;

   logic [W-1:0]  data_out, data_out0;
   logic          ser_out, busy, done, ser_out0, busy0, done0;
   logic [3:0]    bit_cnt, bit_cnt0;

   usr_frame_ser #(.WIDTH(W), .ROT_EN(1'b1)) dut (
      .clk(clk), .RST(RST), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
      .par_load(par_load), .start(start), .data_out(data_out), .ser_out(ser_out),
      .busy(busy), .done(done), .bit_cnt(bit_cnt)
   );

   usr_frame_ser #(.WIDTH(W), .ROT_EN(1'b0)) dut_norot (
      .clk(clk), .RST(RST), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
      .par_load(par_load), .start(start), .data_out(data_out0), .ser_out(ser_out0),
      .busy(busy0), .done(done0), .bit_cnt(bit_cnt0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic         ser;
      logic         busy;
      logic         done;
      logic [3:0]   cnt;
      logic [W-1:0] data0;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   event chk_now;

   // reference model: register value, codeword of the running frame and bits still to go
   logic [W-1:0] m_data, m_data0, m_code;
   int           m_left;
   logic         m_done;

   function automatic logic [W-1:0] manual(input logic [W-1:0] d, input logic [2:0] md,
                                           input logic sri, input logic sli,
                                           input logic [W-1:0] pl, input bit rot);
      logic [W-1:0] mask = '1;
      case (md)
         3'd1: return (d >> 1) | (W'(sri) << (W - 1));
         3'd2: return ((d << 1) | W'(sli)) & mask;
         3'd3: return rot ? ((d >> 1) | (W'(d[0]) << (W - 1))) : d;
         3'd4: return rot ? (((d << 1) | (d >> (W - 1))) & mask) : d;
         3'd5: return pl;
         default: return d;
      endcase
   endfunction

   task automatic model_reset();
      m_data = '0; m_data0 = '0; m_code = '0; m_left = 0; m_done = 1'b0;
   endtask

   task automatic model_step(input logic [2:0] md, input logic s, input logic sri,
                             input logic sli, input logic [W-1:0] pl, input logic rst_v);
      if (!rst_v) begin
         model_reset();
      end else if (m_left == 0) begin
         m_done = 1'b0;
         if (s) begin
            m_code = pl; m_data = pl; m_data0 = pl; m_left = W;
         end else begin
            m_data  = manual(m_data,  md, sri, sli, pl, 1'b1);
            m_data0 = manual(m_data0, md, sri, sli, pl, 1'b0);
         end
      end else begin
         m_data  = (m_data  >> 1) | (W'(sri) << (W - 1));
         m_data0 = (m_data0 >> 1) | (W'(sri) << (W - 1));
         m_left  = m_left - 1;
         m_done  = (m_left == 0);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.data  = m_data;
      e.busy  = (m_left > 0);
      e.done  = m_done;
      e.cnt   = 4'(m_left);
      e.ser   = (m_left > 0) ? m_code[W - m_left] : m_data[0];
      e.data0 = m_data0;
      q.push_back(e);
   endtask

   task automatic cycle(input logic [2:0] md, input logic s, input logic sri,
                        input logic sli, input logic [W-1:0] pl, input logic rst_v);
      @(negedge clk);
      RST = rst_v; mode = md; start = s; sr_in = sri; sl_in = sli; par_load = pl;
      model_step(md, s, sri, sli, pl, rst_v);
      push_exp();
   endtask

   task automatic async_rst();
      @(negedge clk);
      #2;
      RST = 1'b0;
      model_reset();
      push_exp();
      ->chk_now;
      #2;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk or chk_now);
         #1;
         while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            chk("data_out", 64'(data_out), 64'(e.data));
            chk("ser_out",  64'(ser_out),  64'(e.ser));
            chk("busy",     64'(busy),     64'(e.busy));
            chk("done",     64'(done),     64'(e.done));
            chk("bit_cnt",  64'(bit_cnt),  64'(e.cnt));
            chk("data_out_norot", 64'(data_out0), 64'(e.data0));
         end
      end
   end

   initial begin
      int guard;
      model_reset();
      repeat (2) cycle(3'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

      // async reset from an all-ones register, observed between edges
      cycle(3'd5, 1'b0, 1'b0, 1'b0, 15'h7FFF, 1'b1);
      cycle(3'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      async_rst();
      cycle(3'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

      // manual load / shift / rotate
      cycle(3'd5, 1'b0, 1'b0, 1'b0, 15'h1234, 1'b1);
      repeat (3) cycle(3'd1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      cycle(3'd2, 1'b0, 1'b0, 1'b1, '0, 1'b1);
      cycle(3'd5, 1'b0, 1'b0, 1'b0, 15'h4001, 1'b1);
      cycle(3'd4, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      cycle(3'd5, 1'b0, 1'b0, 1'b0, 15'h4001, 1'b1);
      cycle(3'd3, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      cycle(3'd5, 1'b0, 1'b0, 1'b0, 15'h4001, 1'b1);
      cycle(3'd5, 1'b0, 1'b0, 1'b0, 15'h4001, 1'b1);
      cycle(3'd6, 1'b0, 1'b1, 1'b1, 15'h1111, 1'b1);
      cycle(3'd7, 1'b0, 1'b1, 1'b1, 15'h2222, 1'b1);

      // frame 0x5555, then back-to-back frame 0x0F0F launched in the done cycle
      cycle(3'd0, 1'b1, 1'b0, 1'b0, 15'h5555, 1'b1);
      guard = 0;
      while (!m_done && guard < 40) begin
         cycle(3'd5, 1'b1, 1'b0, 1'b0, 15'h7E7E, 1'b1);
         guard++;
      end
      if (guard >= 40) begin
         n_err++;
         $display("FAIL frame_timeout: no done within %0d cycles", guard);
      end
      cycle(3'd0, 1'b1, 1'b0, 1'b0, 15'h0F0F, 1'b1);

      // abort the second frame with an async reset once 7 bits remain
      guard = 0;
      while (m_left != 7 && guard < 40) begin
         cycle(3'd5, 1'b0, 1'b1, 1'b0, 15'h3C3C, 1'b1);
         guard++;
      end
      async_rst();
      repeat (2) cycle(3'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      cycle(3'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 14) == 0),
               1'($urandom), 1'($urandom), W'($urandom),
               ($urandom_range(0, 249) != 0));
      end

      @(negedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
